hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller and the control-side counterpart of the ID/EX pipeline register.
- Consumes the EX-stage fields leaving ID/EX (rd address, memory-read flag, long-op and branch-taken flags) plus the ID-stage source addresses.
- Drives PC write, IF/ID write/flush and ID/EX bubble/hold controls.
- Handles load-use stalls, multi-cycle EX operations and branch redirect flushes.

Parameters:
- LONG_LAT, 4, total EX occupancy in cycles of a long op; legal range >= 2.
- FLUSH_SLOTS, 1, extra fetch-flush cycles after a taken-branch redirect; 0 disables the FLUSH state.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- id_rs1_addr  in  5  ID-stage rs1 address.
- id_rs2_addr  in  5  ID-stage rs2 address.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_rd_addr  in  5  EX-stage destination register (ID/EX rd address output).
- ex_mem_read  in  1  EX instruction is a load (ID/EX M-field bit).
- ex_long_op  in  1  EX instruction is a multi-cycle ALU op.
- ex_branch_taken  in  1  EX branch/jump resolved taken this cycle.
- pc_we  out  1  PC write enable.
- ifid_we  out  1  IF/ID write enable.
- ifid_flush  out  1  zero IF/ID on next edge.
- idex_bubble  out  1  load zeros (NOP) into ID/EX on next edge.
- idex_hold  out  1  ID/EX keeps current contents.
- exmem_bubble  out  1  insert NOP into EX/MEM.
- long_done  out  1  long op result valid this cycle.
- hz_state  out  2  current state: 0 RUN, 1 LONG_BUSY, 2 FLUSH.

Behaviour:
- Outputs are Mealy: combinational from state, counter and inputs. State and counter are registered.
- While rst is low: state=RUN, cnt=0, pc_we=0, ifid_we=0, ifid_flush=0, idex_bubble=1, idex_hold=0, exmem_bubble=0, long_done=0, hz_state=0.
- Assertion of rst takes effect immediately, including mid-LONG_BUSY or mid-FLUSH.
- Default in RUN with no event: pc_we=1, ifid_we=1, all other outputs 0.
- load_use = ex_mem_read && ex_rd_addr!=0 && ((id_uses_rs1 && id_rs1_addr==ex_rd_addr) || (id_uses_rs2 && id_rs2_addr==ex_rd_addr)).
- RUN priority, highest first:
  1. ex_branch_taken: ifid_flush=1, idex_bubble=1, pc_we=1. If FLUSH_SLOTS>0: cnt<=FLUSH_SLOTS-1, go to FLUSH; else stay in RUN.
  2. ex_long_op: pc_we=0, ifid_we=0, idex_hold=1, exmem_bubble=1. cnt<=LONG_LAT-2, go to LONG_BUSY.
  3. load_use: pc_we=0, ifid_we=0, idex_bubble=1 for exactly one cycle; stay in RUN. The bubble clears ex_mem_read next cycle, so the stall self-terminates.
- LONG_BUSY:
  - cnt!=0: same stall outputs as entry; cnt<=cnt-1.
  - cnt==0: release cycle. long_done=1, pc_we=1, ifid_we=1, idex_hold=0, exmem_bubble=0; go to RUN.
  - ex_branch_taken and load_use are ignored in this state.
  - Total stalled cycles = LONG_LAT-1.
- FLUSH:
  - ifid_flush=1, pc_we=1, ifid_we=1, load_use suppressed.
  - cnt==0 → RUN; else cnt<=cnt-1.
  - ex_branch_taken here reloads cnt<=FLUSH_SLOTS-1 and also asserts idex_bubble.
- ex_long_op together with ex_branch_taken from the same instruction: branch wins and the long op is dropped.
- Register x0 never produces a load-use stall.
- cnt width is clog2(max(LONG_LAT,FLUSH_SLOTS)+1), with a minimum of 1 bit; cnt never wraps.

Optional Feature:
- HAZARD_PERF_EN defined: adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0].
  - perf_stall_cnt increments every cycle rst is high and pc_we==0.
  - perf_flush_cnt increments every cycle ifid_flush==1.
  - Both counters wrap at 2^32 and are reset to 0 by rst.
- HAZARD_PERF_EN undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst=0 mid-LONG_BUSY (cnt=1) → outputs at reset values immediately; after release, hz_state=0, pc_we=1, ifid_we=1.
- Load-use: ex_mem_read=1, ex_rd_addr=5, id_rs2_addr=5, id_uses_rs2=1 → pc_we=0, ifid_we=0, idex_bubble=1 for one cycle. With ex_rd_addr=0 → no stall.
- Long op, LONG_LAT=4: ex_long_op=1 in RUN → stall for 3 cycles (hz_state 0,1,1), then long_done=1 and pc_we=1 on cycle 4, with hz_state back to 0 on the following cycle.
- Branch, FLUSH_SLOTS=2: ex_branch_taken=1 → cycle 0 ifid_flush=1 and idex_bubble=1; FLUSH for 2 more cycles with ifid_flush=1; then RUN.
- Simultaneous events: ex_branch_taken=1, ex_long_op=1 and load_use all true → branch path only, with no stall (pc_we=1).
- HAZARD_PERF_EN: run the long op (3 stall cycles) then the branch (3 flush cycles) → perf_stall_cnt=3, perf_flush_cnt=3.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller paired with the ID/EX register.
// Resolves load-use stalls, multi-cycle EX ops and taken-branch flushes.
// Optional build macro HAZARD_PERF_EN adds stall/flush performance counters.
module hazard_ctrl #(
   parameter int LONG_LAT    = 4,
   parameter int FLUSH_SLOTS = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] id_rs1_addr,
   input  logic [4:0] id_rs2_addr,
   input  logic       id_uses_rs1,
   input  logic       id_uses_rs2,
   input  logic [4:0] ex_rd_addr,
   input  logic       ex_mem_read,
   input  logic       ex_long_op,
   input  logic       ex_branch_taken,
   output logic       pc_we,
   output logic       ifid_we,
   output logic       ifid_flush,
   output logic       idex_bubble,
   output logic       idex_hold,
   output logic       exmem_bubble,
   output logic       long_done,
   output logic [1:0] hz_state
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_flush_cnt
`endif
);

   localparam int MAXV = (LONG_LAT > FLUSH_SLOTS) ? LONG_LAT : FLUSH_SLOTS;
   localparam int CW   = ($clog2(MAXV + 1) < 1) ? 1 : $clog2(MAXV + 1);

   // Counter reload values: LONG_BUSY covers LONG_LAT-1 cycles after the entry cycle,
   // FLUSH covers FLUSH_SLOTS cycles after the redirect cycle.
   localparam logic [CW-1:0] LONG_RELOAD  = CW'(LONG_LAT - 2);
   localparam logic [CW-1:0] FLUSH_RELOAD = (FLUSH_SLOTS > 0) ? CW'(FLUSH_SLOTS - 1) : '0;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_LONG  = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          load_use;

   // x0 is hardwired, so a load targeting it can never create a dependency
   assign load_use = ex_mem_read && (ex_rd_addr != 5'd0) &&
                     ((id_uses_rs1 && (id_rs1_addr == ex_rd_addr)) ||
                      (id_uses_rs2 && (id_rs2_addr == ex_rd_addr)));

   // State and counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic and Mealy control outputs; reset forces the safe NOP pattern
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      pc_we        = 1'b1;
      ifid_we      = 1'b1;
      ifid_flush   = 1'b0;
      idex_bubble  = 1'b0;
      idex_hold    = 1'b0;
      exmem_bubble = 1'b0;
      long_done    = 1'b0;
      hz_state     = state_q;

      case (state_q)
         ST_RUN: begin
            if (ex_branch_taken) begin
               // redirect wins; any long op from the same instruction is dropped
               ifid_flush  = 1'b1;
               idex_bubble = 1'b1;
               if (FLUSH_SLOTS > 0) begin
                  cnt_d   = FLUSH_RELOAD;
                  state_d = ST_FLUSH;
               end
            end else if (ex_long_op) begin
               pc_we        = 1'b0;
               ifid_we      = 1'b0;
               idex_hold    = 1'b1;
               exmem_bubble = 1'b1;
               cnt_d        = LONG_RELOAD;
               state_d      = ST_LONG;
            end else if (load_use) begin
               // bubble clears ex_mem_read next cycle, so this lasts one cycle
               pc_we       = 1'b0;
               ifid_we     = 1'b0;
               idex_bubble = 1'b1;
            end
         end
         ST_LONG: begin
            if (cnt_q != '0) begin
               pc_we        = 1'b0;
               ifid_we      = 1'b0;
               idex_hold    = 1'b1;
               exmem_bubble = 1'b1;
               cnt_d        = cnt_q - CW'(1);
            end else begin
               long_done = 1'b1;
               state_d   = ST_RUN;
            end
         end
         ST_FLUSH: begin
            ifid_flush = 1'b1;
            if (ex_branch_taken) begin
               idex_bubble = 1'b1;
               cnt_d       = FLUSH_RELOAD;
            end else if (cnt_q == '0) begin
               state_d = ST_RUN;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            state_d = ST_RUN;
            cnt_d   = '0;
         end
      endcase

      if (!rst) begin
         state_d      = ST_RUN;
         cnt_d        = '0;
         pc_we        = 1'b0;
         ifid_we      = 1'b0;
         ifid_flush   = 1'b0;
         idex_bubble  = 1'b1;
         idex_hold    = 1'b0;
         exmem_bubble = 1'b0;
         long_done    = 1'b0;
         hz_state     = ST_RUN;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] perf_stall_q, perf_flush_q;

   // Free-running stall and flush cycle counters, wrapping at 2^32
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_stall_q <= '0;
         perf_flush_q <= '0;
      end else begin
         if (!pc_we)     perf_stall_q <= perf_stall_q + 32'd1;
         if (ifid_flush) perf_flush_q <= perf_flush_q + 32'd1;
      end
   end

   assign perf_stall_cnt = perf_stall_q;
   assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl with LONG_LAT=4, FLUSH_SLOTS=2.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [4:0] id_rs1_addr = '0, id_rs2_addr = '0, ex_rd_addr = '0;
   logic       id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
   logic       ex_mem_read = 1'b0, ex_long_op = 1'b0, ex_branch_taken = 1'b0;
   logic       pc_we, ifid_we, ifid_flush, idex_bubble, idex_hold, exmem_bubble, long_done;
   logic [1:0] hz_state;
`ifdef HAZARD_PERF_EN
   logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // {pc_we, ifid_we, ifid_flush, idex_bubble, idex_hold, exmem_bubble, long_done, hz_state}
   logic [8:0] outs;
   assign outs = {pc_we, ifid_we, ifid_flush, idex_bubble, idex_hold,
                  exmem_bubble, long_done, hz_state};

   localparam logic [8:0] RST_O   = 9'b0_0_0_1_0_0_0_00;
   localparam logic [8:0] RUN_O   = 9'b1_1_0_0_0_0_0_00;
   localparam logic [8:0] LU_O    = 9'b0_0_0_1_0_0_0_00;
   localparam logic [8:0] BR_O    = 9'b1_1_1_1_0_0_0_00;
   localparam logic [8:0] LENT_O  = 9'b0_0_0_0_1_1_0_00;
   localparam logic [8:0] LBUSY_O = 9'b0_0_0_0_1_1_0_01;
   localparam logic [8:0] LREL_O  = 9'b1_1_0_0_0_0_1_01;
   localparam logic [8:0] FL_O    = 9'b1_1_1_0_0_0_0_10;
   localparam logic [8:0] FLBR_O  = 9'b1_1_1_1_0_0_0_10;

   hazard_ctrl #(.LONG_LAT(4), .FLUSH_SLOTS(2)) dut (
      .clk(clk), .rst(rst),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read),
      .ex_long_op(ex_long_op), .ex_branch_taken(ex_branch_taken),
      .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
      .idex_bubble(idex_bubble), .idex_hold(idex_hold),
      .exmem_bubble(exmem_bubble), .long_done(long_done), .hz_state(hz_state)
`ifdef HAZARD_PERF_EN
      , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic mr, input logic lo, input logic bt);
      id_rs1_addr     = rs1;
      id_rs2_addr     = rs2;
      id_uses_rs1     = u1;
      id_uses_rs2     = u2;
      ex_rd_addr      = rd;
      ex_mem_read     = mr;
      ex_long_op      = lo;
      ex_branch_taken = bt;
   endtask

   // Apply inputs just after the falling edge, then check the settled Mealy outputs
   task automatic step(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic mr, input logic lo, input logic bt,
                       input logic [8:0] exp);
      @(negedge clk);
      drive(rs1, rs2, u1, u2, rd, mr, lo, bt);
      #1;
      chk(tag, {23'd0, outs}, {23'd0, exp});
      $display("step %s outs=%09b exp=%09b", tag, outs, exp);
   endtask

   initial begin
      // Reset held
      #1;
      chk("reset_outs", {23'd0, outs}, {23'd0, RST_O});
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("run_idle", {23'd0, outs}, {23'd0, RUN_O});

      // Long op: 3 stalled cycles, branch/load-use ignored while busy, release with long_done
      step("long_entry", 0, 0, 0, 0, 0, 0, 1, 0, LENT_O);
      step("long_busy2", 0, 5, 0, 1, 5, 1, 1, 1, LBUSY_O);
      step("long_busy1", 0, 0, 0, 0, 0, 0, 1, 0, LBUSY_O);
      step("long_release", 0, 0, 0, 0, 0, 0, 1, 0, LREL_O);
      step("long_after", 0, 0, 0, 0, 0, 0, 0, 0, RUN_O);

      // Branch redirect followed by two FLUSH cycles; load-use suppressed in FLUSH
      step("br_redirect", 0, 0, 0, 0, 0, 0, 0, 1, BR_O);
      step("br_flush1", 0, 0, 0, 0, 0, 0, 0, 0, FL_O);
      step("br_flush0_lu", 0, 5, 0, 1, 5, 1, 0, 0, FL_O);
      step("br_after", 0, 0, 0, 0, 0, 0, 0, 0, RUN_O);
`ifdef HAZARD_PERF_EN
      chk("perf_stall", perf_stall_cnt, 32'd3);
      chk("perf_flush", perf_flush_cnt, 32'd3);
`endif

      // Branch inside FLUSH reloads the counter
      step("br2_redirect", 0, 0, 0, 0, 0, 0, 0, 1, BR_O);
      step("br2_in_flush", 0, 0, 0, 0, 0, 0, 0, 1, FLBR_O);
      step("br2_flush1", 0, 0, 0, 0, 0, 0, 0, 0, FL_O);
      step("br2_flush0", 0, 0, 0, 0, 0, 0, 0, 0, FL_O);
      step("br2_after", 0, 0, 0, 0, 0, 0, 0, 0, RUN_O);

      // Load-use cases
      step("lu_rs2", 0, 5, 0, 1, 5, 1, 0, 0, LU_O);
      step("lu_clear", 0, 5, 0, 1, 5, 0, 0, 0, RUN_O);
      step("lu_rs1", 7, 0, 1, 0, 7, 1, 0, 0, LU_O);
      step("lu_rs1_unused", 7, 0, 0, 0, 7, 1, 0, 0, RUN_O);
      step("lu_x0", 0, 0, 1, 1, 0, 1, 0, 0, RUN_O);
      step("lu_no_match", 3, 4, 1, 1, 5, 1, 0, 0, RUN_O);

      // Branch + long op + load-use together: branch path only
      step("simul_branch", 0, 5, 0, 1, 5, 1, 1, 1, BR_O);
      step("simul_flush1", 0, 0, 0, 0, 0, 0, 0, 0, FL_O);
      step("simul_flush0", 0, 0, 0, 0, 0, 0, 0, 0, FL_O);
      step("simul_after", 0, 0, 0, 0, 0, 0, 0, 0, RUN_O);

      // Asynchronous reset in the middle of LONG_BUSY (cnt=1)
      step("rl_entry", 0, 0, 0, 0, 0, 0, 1, 0, LENT_O);
      step("rl_busy2", 0, 0, 0, 0, 0, 0, 1, 0, LBUSY_O);
      step("rl_busy1", 0, 0, 0, 0, 0, 0, 1, 0, LBUSY_O);
      #1;
      rst = 1'b0;
      #1;
      chk("rl_async_reset", {23'd0, outs}, {23'd0, RST_O});
`ifdef HAZARD_PERF_EN
      chk("perf_stall_rst", perf_stall_cnt, 32'd0);
      chk("perf_flush_rst", perf_flush_cnt, 32'd0);
`endif
      @(posedge clk);
      #1;
      chk("rl_reset_held", {23'd0, outs}, {23'd0, RST_O});
      @(negedge clk);
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("rl_released", {23'd0, outs}, {23'd0, RUN_O});
      step("rl_run", 0, 0, 0, 0, 0, 0, 0, 0, RUN_O);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
